// File: rtl/accel_job_sched.sv
// Wishbone-slave job scheduler: queues accelerator job descriptors, issues them one
// at a time over valid/ready, supervises each run with a watchdog and raises an irq.
`timescale 1ns/1ps

module accel_job_sched #(
    parameter int DEPTH = 4,
    parameter int TMO_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        job_valid,
    input  logic        job_ready,
    output logic [31:0] job_desc,
    input  logic        acc_done,
    output logic        acc_abort,
    output logic        busy,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             full, empty;
    logic             enable, irq_en, flush_q;
    logic             irq_pend, overflow, timeout_err;
    logic [15:0]      done_cnt;
    logic [TMO_W-1:0] timeout, wdt_cnt;

    logic [2:0]  reg_idx;
    logic        wb_req, wb_wr, wb_rd;
    logic        wr_ctrl, wr_status, wr_push, wr_tmo;
    logic [2:0]  w1c;
    logic        pop_eff, push_ok, overflow_set, wdt_expire;
    logic        irq_pend_nxt, overflow_nxt, timeout_err_nxt, irq_en_nxt;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign reg_idx   = wbs_adr_i[4:2];
    assign wb_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_wr     = wb_req & wbs_we_i;
    assign wb_rd     = wb_req & ~wbs_we_i;
    assign wr_ctrl   = wb_wr && (reg_idx == 3'd0);
    assign wr_status = wb_wr && (reg_idx == 3'd1);
    assign wr_push   = wb_wr && (reg_idx == 3'd2);
    assign wr_tmo    = wb_wr && (reg_idx == 3'd4);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
    assign pop_eff      = (state == S_ISSUE) & job_ready & ~empty;
    assign push_ok      = wr_push & ~flush_q & (~full | pop_eff);
    assign overflow_set = wr_push & ~flush_q & full & ~pop_eff;

    // Expiry on the TIMEOUT-th RUN cycle; a same-cycle acc_done takes precedence.
    assign wdt_expire = (state == S_RUN) & ~acc_done & (timeout != '0) &
                        (wdt_cnt == timeout - TMO_W'(1));
    assign acc_abort  = wdt_expire & ~wb_rst_i;

    assign job_valid = (state == S_ISSUE);
    assign busy      = (state == S_ISSUE) || (state == S_RUN);

    // Sticky status bits: a set in the same cycle beats the write-1-to-clear.
    assign w1c             = wr_status ? wbs_dat_i[10:8] : 3'b000;
    assign irq_pend_nxt    = (irq_pend & ~w1c[0]) | (state == S_DONE) | wdt_expire;
    assign overflow_nxt    = (overflow & ~w1c[1]) | overflow_set;
    assign timeout_err_nxt = (timeout_err & ~w1c[2]) | wdt_expire;
    assign irq_en_nxt      = wr_ctrl ? wbs_dat_i[1] : irq_en;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves rd_data unassigned (no latch).
        rd_data = '0;
        case (reg_idx)
            3'd0: rd_data = {30'b0, irq_en, enable};
            3'd1: rd_data = {21'b0, timeout_err, overflow, irq_pend, 5'(count), empty, full, busy};
            3'd3: rd_data = {16'b0, done_cnt};
            3'd4: rd_data = 32'(timeout);
            default: rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            flush_q     <= 1'b0;
            irq_pend    <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            timeout     <= '0;
            irq         <= 1'b0;
        end else begin
            wbs_ack_o   <= wb_req;
            wbs_dat_o   <= wb_rd ? rd_data : '0;
            flush_q     <= wr_ctrl & wbs_dat_i[2];
            if (wr_ctrl) begin
                enable <= wbs_dat_i[0];
                irq_en <= wbs_dat_i[1];
            end
            if (wr_tmo) begin
                timeout <= wbs_dat_i[TMO_W-1:0];
            end
            irq_pend    <= irq_pend_nxt;
            overflow    <= overflow_nxt;
            timeout_err <= timeout_err_nxt;
            irq         <= irq_en_nxt & (irq_pend_nxt | timeout_err_nxt);
        end
    end

    // NOTE: descriptor storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush_q) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue is held off during a pending flush so the head being discarded is never offered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            job_desc <= '0;
            wdt_cnt  <= '0;
            done_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && !empty && !flush_q) begin
                        state    <= S_ISSUE;
                        job_desc <= mem[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    if (job_ready) begin
                        wdt_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (acc_done) begin
                        state <= S_DONE;
                    end else if (wdt_expire) begin
                        state <= S_IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    done_cnt <= done_cnt + 16'd1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/accel_job_sched.md
Name: accel_job_sched

Overview:
- Wishbone-slave job scheduler that sits between the management SoC and the AI accelerator datapath.
- Software pushes job descriptors into an internal FIFO.
- The block issues them one at a time to the accelerator over a valid/ready handshake, waits for completion with a watchdog, counts finished jobs and raises an interrupt.

Parameters:
DEPTH, 4, job FIFO entries (power of 2, 2..16)
TMO_W, 16, width of watchdog timeout register/counter

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects (ignored; full-word access only)
wbs_adr_i  in  32  byte address; [4:2] selects register
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  Wishbone acknowledge
wbs_dat_o  out  32  read data
job_valid  out  1  descriptor valid to accelerator
job_ready  in  1  accelerator accepts descriptor
job_desc  out  32  {opcode[31:28], len[27:16], base[15:0]}
acc_done  in  1  one-cycle completion pulse from accelerator
acc_abort  out  1  one-cycle abort pulse on watchdog expiry
busy  out  1  job in flight (ISSUE or RUN)
irq  out  1  interrupt, level

Behaviour:
Reset (wb_rst_i=1 at a clock edge):
- Outputs: wbs_ack_o=0, wbs_dat_o=0, job_valid=0, job_desc=0, acc_abort=0, busy=0, irq=0.
- State: FIFO empty, all registers 0, FSM=IDLE.
- Reset mid-job drops the job silently; no acc_abort is issued.

Wishbone:
- Access when cyc&stb&!ack. wbs_ack_o pulses high exactly 1 cycle later, for 1 cycle. Read data is valid in the ack cycle; side effects commit in the request cycle.
- Unmapped addresses: ack, read 0, writes ignored.

Registers (word index = wbs_adr_i[4:2]):
- 0 CTRL RW. [0] enable, [1] irq_en. [2] flush: write-1, self-clearing, empties FIFO next cycle; the in-flight job is unaffected.
- 1 STATUS. [0] busy, [1] full, [2] empty, [7:3] count, [8] irq_pend, [9] overflow, [10] timeout_err. Bits [10:8] are sticky and write-1-to-clear; the other bits are RO.
- 2 PUSH WO. A write enqueues wbs_dat_i. If full (and no pop in the same cycle), the write is dropped and overflow is set. Reads return 0.
- 3 DONE_CNT RO 16-bit, zero-extended. Wraps 0xFFFF->0.
- 4 TIMEOUT RW [TMO_W-1:0]. 0 disables the watchdog.

FSM:
- IDLE: if enable && !empty -> ISSUE. On entry, job_desc = FIFO head and job_valid=1.
- ISSUE: hold job_valid and job_desc stable until job_ready. On job_valid&&job_ready: pop FIFO, job_valid=0, clear watchdog counter, -> RUN.
- RUN:
  - acc_done -> DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: acc_abort=1 for one cycle, set timeout_err and irq_pend, -> IDLE. The job is not counted.
  - Else the counter increments.
- DONE (1 cycle): DONE_CNT+=1, set irq_pend, -> IDLE.
- Clearing enable does not stop ISSUE or RUN. It only prevents leaving IDLE.
- acc_done outside RUN is ignored.
- busy = (state==ISSUE || state==RUN).
- irq = irq_en & (irq_pend | timeout_err), registered.

Simultaneous events:
- Push and pop in the same cycle: both happen, count unchanged, and a push while full is accepted.
- Flush and push in the same cycle: flush wins and the push is discarded (no overflow).
- W1C clear and a set in the same cycle: set wins.
- acc_done and watchdog expiry in the same cycle: done wins (normal completion).
- Back-to-back: min 1 idle cycle in IDLE between jobs. Issue-to-issue is ≥4 cycles with job_ready=1 and acc_done on the first RUN cycle.

Test Plan:
- Reset, read STATUS -> 0x4 (empty); CTRL, DONE_CNT, TIMEOUT all read 0; ack 1 cycle after each request.
- CTRL=0x3; push 0x1003_0100; job_ready=1; acc_done 5 cycles later.
  -> job_desc=0x10030100 for exactly 1 valid cycle; DONE_CNT=1; irq=1.
  -> Write STATUS 0x100 -> irq=0 next cycle.
- enable=0; push DEPTH+1 descriptors.
  -> STATUS full=1, count=4, overflow=1.
  -> Set enable with job_ready held 0: job_valid stays high with the head descriptor stable for 10 cycles.
- TIMEOUT=8; job accepted; acc_done never arrives.
  -> acc_abort pulses on the 8th RUN cycle; timeout_err=1; DONE_CNT unchanged; next queued job issues.
- Push 3 jobs, write flush during the first job's RUN.
  -> First job completes (DONE_CNT+1); FIFO empty; no further job_valid.
- Same-cycle push while full and pop (job_ready in ISSUE) -> count stays 4, overflow stays 0.
  Assert wb_rst_i during RUN -> all outputs 0 next cycle and acc_abort not pulsed.
